// File: rtl/user_input_conditioner.sv
// Synchronizes and debounces a raw user input, then emits one-cycle pulses on debounced edges.
// Optional HIGH2LOW_PULSE_EN adds the fall_pulse output; without it the falling edge is tracked silently.
module user_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic level,
  output logic rise_pulse
`ifdef HIGH2LOW_PULSE_EN
  ,
  output logic fall_pulse
`endif
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The cycle that leaves LOW/HIGH already counts as the first sample of the new value.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {LOW, RISE_WAIT, HIGH, FALL_WAIT} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             s1, s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOW;
      cnt        <= '0;
      rise_pulse <= 1'b0;
`ifdef HIGH2LOW_PULSE_EN
      fall_pulse <= 1'b0;
`endif
    end else begin
      rise_pulse <= 1'b0;
`ifdef HIGH2LOW_PULSE_EN
      fall_pulse <= 1'b0;
`endif
      unique case (state)
        LOW: begin
          if (s2) begin
            state <= RISE_WAIT;
            cnt   <= CNT_W'(1);
          end else begin
            cnt   <= '0;
          end
        end
        RISE_WAIT: begin
          if (!s2) begin
            state <= LOW;
            cnt   <= '0;
          end else if (cnt >= CNT_LAST) begin
            state      <= HIGH;
            cnt        <= '0;
            rise_pulse <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HIGH: begin
          if (!s2) begin
            state <= FALL_WAIT;
            cnt   <= CNT_W'(1);
          end else begin
            cnt   <= '0;
          end
        end
        FALL_WAIT: begin
          if (s2) begin
            state <= HIGH;
            cnt   <= '0;
          end else if (cnt >= CNT_LAST) begin
            state <= LOW;
            cnt   <= '0;
`ifdef HIGH2LOW_PULSE_EN
            fall_pulse <= 1'b1;
`endif
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= LOW;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign level = (state == HIGH) || (state == FALL_WAIT);

endmodule

// File: tb/tb_user_input_conditioner.sv
// Directed vector bench for user_input_conditioner (DEBOUNCE_CYCLES=4); works with or without HIGH2LOW_PULSE_EN.
module tb_user_input_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in  = 1'b0;
  logic level, rise_pulse;
`ifdef HIGH2LOW_PULSE_EN
  logic fall_pulse;
`endif

  int checks = 0;
  int errors = 0;

  user_input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .level      (level),
    .rise_pulse (rise_pulse)
`ifdef HIGH2LOW_PULSE_EN
    ,
    .fall_pulse (fall_pulse)
`endif
  );

  always #1 clk = ~clk;

  typedef struct {
    logic rst;
    logic in;
    logic lvl;
    logic rise;
    logic fall;
    string tag;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic i, input logic l, input logic rs,
                     input logic fl, input string tag);
    vec_t v;
    v.rst = r; v.in = i; v.lvl = l; v.rise = rs; v.fall = fl; v.tag = tag;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Apply inputs, let one posedge happen, then sample on the following negedge.
  task automatic step(input logic r, input logic i);
    rst = r;
    in  = i;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_outs(input string name, input logic l, input logic rs, input logic fl);
    chk({name, ".level"}, level, l);
    chk({name, ".rise"}, rise_pulse, rs);
`ifdef HIGH2LOW_PULSE_EN
    chk({name, ".fall"}, fall_pulse, fl);
`else
    if (fl === 1'b1 && fl === 1'b0) $display("unreachable");
`endif
  endtask

  initial begin
    int n;
    int rise_at;

    // Reset held with input high
    for (int k = 1; k <= 3; k++) add(1, 1, 0, 0, 0, $sformatf("rst%0d", k));
    // Release with input held high: rise on the 6th posedge
    for (int k = 1; k <= 20; k++)
      add(0, 1, (k >= 6), (k == 6), 0, $sformatf("hold_hi%0d", k));
    // Input drops and stays low: fall on the 6th posedge
    for (int k = 1; k <= 12; k++)
      add(0, 0, (k < 6), 0, (k == 6), $sformatf("hold_lo%0d", k));
    // Three-cycle glitch is rejected
    for (int k = 1; k <= 3; k++) add(0, 1, 0, 0, 0, $sformatf("short_hi%0d", k));
    for (int k = 1; k <= 8; k++) add(0, 0, 0, 0, 0, $sformatf("short_lo%0d", k));
    // Single-cycle toggles are rejected
    for (int k = 1; k <= 8; k++)
      add(0, (k <= 4) ? ((k % 2) == 1) : 1'b0, 0, 0, 0, $sformatf("toggle%0d", k));
    // Bounce 1,0,1 then steady: one rise 6 posedges after the last 0->1
    add(0, 1, 0, 0, 0, "bounce1");
    add(0, 0, 0, 0, 0, "bounce2");
    for (int k = 3; k <= 14; k++)
      add(0, 1, (k >= 8), (k == 8), 0, $sformatf("bounce%0d", k));
    // Release again to leave the block idle low
    for (int k = 1; k <= 8; k++)
      add(0, 0, (k < 6), 0, (k == 6), $sformatf("rel_lo%0d", k));

    foreach (vq[j]) begin
      step(vq[j].rst, vq[j].in);
      chk_outs(vq[j].tag, vq[j].lvl, vq[j].rise, vq[j].fall);
    end

    // Reset in the middle of RISE_WAIT aborts the pending rise
    step(0, 1);
    step(0, 1);
    step(0, 1);
    chk_outs("mid_wait", 0, 0, 0);
    step(1, 1);
    chk_outs("mid_rst", 0, 0, 0);
    rise_at = 0;
    for (n = 1; n <= 20; n++) begin
      step(0, 1);
      if (rise_pulse === 1'b1) begin
        rise_at = n;
        break;
      end
    end
    checks++;
    if (rise_at != 6) begin
      errors++;
      $display("FAIL post_rst_rise: rise at posedge %0d expected 6", rise_at);
    end
    chk_outs("post_rst_lvl", 1, 1, 0);
    step(0, 1);
    chk_outs("post_rst_once", 1, 0, 0);
    for (int k = 0; k < 10; k++) step(0, 1);
    chk_outs("post_rst_hold", 1, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
